// File: rtl/alu_sequencer.sv
// Command-level sequencer for the 8-bit accumulator ALU: accepts one command per handshake
// and drives the ALU strobes over one or more cycles, ending with a done (and optional err) pulse.
//
//   state  | meaning
//   IDLE   | ready for a command
//   LOAD   | tmp register written with the operand (binary ops only)
//   EXEC   | ALU op strobed, exactly one cycle
//   WRITE  | single acc/flags/save/restore strobe
//   SETTLE | wait SETTLE_CYCLES after EXEC
//   DONE   | one-cycle done (err for rejected commands)
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cmd,
  input  logic [4:0] req_opcode,
  input  logic [7:0] req_operand,
  output logic       done,
  output logic       err,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_data,
  output logic       alu_ctrl_sig,
  output logic       alu_tmp_we,
  output logic       alu_acc_we,
  output logic       alu_flags_we,
  output logic       alu_act_store,
  output logic       alu_act_restore
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  localparam logic [2:0] CMD_OP_BIN   = 3'd0;
  localparam logic [2:0] CMD_OP_UN    = 3'd1;
  localparam logic [2:0] CMD_LD_ACC   = 3'd2;
  localparam logic [2:0] CMD_LD_FLAGS = 3'd3;
  localparam logic [2:0] CMD_SAVE     = 3'd4;
  localparam logic [2:0] CMD_RESTORE  = 3'd5;

  localparam logic [4:0] OPC_BIN_MAX = 5'h07;
  localparam logic [4:0] OPC_UN_MIN  = 5'h08;
  localparam logic [4:0] OPC_UN_MAX  = 5'h11;
  localparam logic [4:0] OPC_DAA     = 5'h0C;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXEC   = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cmd_legal;
  logic          accept;
  logic          done_nxt, err_nxt;
  logic          ctrl_nxt, tmp_nxt, acc_nxt, flags_nxt, store_nxt, restore_nxt;

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  always_comb begin
    cmd_legal = 1'b0;
    case (req_cmd)
      CMD_OP_BIN:   cmd_legal = (req_opcode <= OPC_BIN_MAX);
      CMD_OP_UN:    cmd_legal = (req_opcode >= OPC_UN_MIN) && (req_opcode <= OPC_UN_MAX) &&
                                (req_opcode != OPC_DAA);
      CMD_LD_ACC,
      CMD_LD_FLAGS,
      CMD_SAVE,
      CMD_RESTORE:  cmd_legal = 1'b1;
      default:      cmd_legal = 1'b0;
    endcase
  end

  // Strobes are computed for the coming cycle and registered, so each one is a clean flop output.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    ctrl_nxt    = 1'b0;
    tmp_nxt     = 1'b0;
    acc_nxt     = 1'b0;
    flags_nxt   = 1'b0;
    store_nxt   = 1'b0;
    restore_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!cmd_legal) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            case (req_cmd)
              CMD_OP_BIN:   begin state_nxt = LOAD;  tmp_nxt     = 1'b1; end
              CMD_OP_UN:    begin state_nxt = EXEC;  ctrl_nxt    = 1'b1; end
              CMD_LD_ACC:   begin state_nxt = WRITE; acc_nxt     = 1'b1; end
              CMD_LD_FLAGS: begin state_nxt = WRITE; flags_nxt   = 1'b1; end
              CMD_SAVE:     begin state_nxt = WRITE; store_nxt   = 1'b1; end
              CMD_RESTORE:  begin state_nxt = WRITE; restore_nxt = 1'b1; end
              default: begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
                err_nxt   = 1'b1;
              end
            endcase
          end
        end
      end
      LOAD: begin
        state_nxt = EXEC;
        ctrl_nxt  = 1'b1;
      end
      EXEC: begin
        if (SETTLE_CYCLES == 0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LAST;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WRITE: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done            <= 1'b0;
      err             <= 1'b0;
      alu_ctrl_sig    <= 1'b0;
      alu_tmp_we      <= 1'b0;
      alu_acc_we      <= 1'b0;
      alu_flags_we    <= 1'b0;
      alu_act_store   <= 1'b0;
      alu_act_restore <= 1'b0;
    end else begin
      done            <= done_nxt;
      err             <= err_nxt;
      alu_ctrl_sig    <= ctrl_nxt;
      alu_tmp_we      <= tmp_nxt;
      alu_acc_we      <= acc_nxt;
      alu_flags_we    <= flags_nxt;
      alu_act_store   <= store_nxt;
      alu_act_restore <= restore_nxt;
    end
  end

  // Opcode and data are captured only at accept and held for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_data   <= '0;
    end else if (accept) begin
      alu_opcode <= req_opcode;
      alu_data   <= req_operand;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (SETTLE_CYCLES 1 and 0) share stimulus and are each
// compared every cycle against a schedule-based reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_cmd;
  logic [4:0] req_opcode;
  logic [7:0] req_operand;

  logic [1:0] ready_o, done_o, err_o, ctrl_o, tmp_o, acc_o, flags_o, store_o, restore_o;
  logic [4:0] opc_o [2];
  logic [7:0] dat_o [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[0]),
    .req_cmd(req_cmd), .req_opcode(req_opcode), .req_operand(req_operand),
    .done(done_o[0]), .err(err_o[0]), .alu_opcode(opc_o[0]), .alu_data(dat_o[0]),
    .alu_ctrl_sig(ctrl_o[0]), .alu_tmp_we(tmp_o[0]), .alu_acc_we(acc_o[0]),
    .alu_flags_we(flags_o[0]), .alu_act_store(store_o[0]), .alu_act_restore(restore_o[0])
  );

  alu_sequencer #(.SETTLE_CYCLES(0)) dut_n0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[1]),
    .req_cmd(req_cmd), .req_opcode(req_opcode), .req_operand(req_operand),
    .done(done_o[1]), .err(err_o[1]), .alu_opcode(opc_o[1]), .alu_data(dat_o[1]),
    .alu_ctrl_sig(ctrl_o[1]), .alu_tmp_we(tmp_o[1]), .alu_acc_we(acc_o[1]),
    .alu_flags_we(flags_o[1]), .alu_act_store(store_o[1]), .alu_act_restore(restore_o[1])
  );

  // Strobe vector layout: {done, err, ctrl, tmp, acc, flags, store, restore}
  localparam logic [7:0] V_DONE = 8'h80, V_DERR = 8'hC0, V_CTRL = 8'h20, V_TMP = 8'h10;
  localparam logic [7:0] V_ACC = 8'h08, V_FLAGS = 8'h04, V_STORE = 8'h02, V_RESTORE = 8'h01;

  int         n_settle [2] = '{1, 0};
  logic [7:0] sched [2][0:15];
  int         slen [2];
  int         spos [2];
  logic [7:0] exp_strb [2];
  logic       exp_busy [2];
  logic [4:0] exp_opc [2];
  logic [7:0] exp_dat [2];
  logic       acc_evt [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] strb(input int i);
    return {done_o[i], err_o[i], ctrl_o[i], tmp_o[i], acc_o[i], flags_o[i], store_o[i], restore_o[i]};
  endfunction

  function automatic bit legal(input logic [2:0] c, input logic [4:0] o);
    case (c)
      3'd0:    return o <= 5'd7;
      3'd1:    return (o >= 5'd8) && (o <= 5'd17) && (o != 5'd12);
      3'd2, 3'd3, 3'd4, 3'd5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input int i, input logic [7:0] v);
    sched[i][slen[i]] = v;
    slen[i]++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      slen[i] = 0; spos[i] = 0; exp_strb[i] = '0; exp_busy[i] = 1'b0;
      exp_opc[i] = '0; exp_dat[i] = '0; acc_evt[i] = 1'b0;
    end
  endtask

  // Called right after each posedge: decide acceptance, then pop the current cycle's expectation.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      acc_evt[i] = 1'b0;
      if (!exp_busy[i] && req_valid) begin
        acc_evt[i] = 1'b1;
        exp_opc[i] = req_opcode;
        exp_dat[i] = req_operand;
        slen[i] = 0; spos[i] = 0;
        if (!legal(req_cmd, req_opcode)) push(i, V_DERR);
        else begin
          case (req_cmd)
            3'd0: begin push(i, V_TMP); push(i, V_CTRL); end
            3'd1: push(i, V_CTRL);
            3'd2: push(i, V_ACC);
            3'd3: push(i, V_FLAGS);
            3'd4: push(i, V_STORE);
            default: push(i, V_RESTORE);
          endcase
          if (req_cmd <= 3'd1)
            for (int k = 0; k < n_settle[i]; k++) push(i, 8'h00);
          push(i, V_DONE);
        end
      end
      if (spos[i] < slen[i]) begin
        exp_strb[i] = sched[i][spos[i]];
        spos[i]++;
        exp_busy[i] = 1'b1;
      end else begin
        exp_strb[i] = '0;
        exp_busy[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("strobes[%0d]", i), 32'(strb(i)), 32'(exp_strb[i]));
      check_eq($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(!exp_busy[i]));
      check_eq($sformatf("opcode[%0d]", i), 32'(opc_o[i]), 32'(exp_opc[i]));
      check_eq($sformatf("data[%0d]", i), 32'(dat_o[i]), 32'(exp_dat[i]));
    end
  endtask

  task automatic cyc(input logic v, input logic [2:0] c, input logic [4:0] o, input logic [7:0] d);
    @(negedge clk);
    compare_all();
    req_valid = v; req_cmd = c; req_opcode = o; req_operand = d;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'($urandom), 5'($urandom), 8'($urandom));
  endtask

  // Hold req_valid with the command until the SETTLE_CYCLES=1 instance takes it.
  task automatic send(input logic [2:0] c, input logic [4:0] o, input logic [7:0] d);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc(1'b1, c, o, d);
      got = acc_evt[0];
    end
    check_eq("send_accept", 32'(got), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_opcode = '0; req_operand = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_strobes[%0d]", i), 32'(strb(i)), 32'd0);
      check_eq($sformatf("rst_ready[%0d]", i), 32'(ready_o[i]), 32'd0);
      check_eq($sformatf("rst_opcode[%0d]", i), 32'(opc_o[i]), 32'd0);
      check_eq($sformatf("rst_data[%0d]", i), 32'(dat_o[i]), 32'd0);
    end
    rst = 1'b0;

    // Reset mid-EXEC drops strobes at once and loses the command
    cyc(1'b1, 3'd1, 5'h10, 8'h00);
    #2;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("exec_ctrl[%0d]", i), 32'(ctrl_o[i]), 32'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("async_rst_strobes[%0d]", i), 32'(strb(i)), 32'd0);
      check_eq($sformatf("async_rst_ready[%0d]", i), 32'(ready_o[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    idle(4);

    // OP_BIN ADD 0x05, OP_UN INR
    send(3'd0, 5'h00, 8'h05);
    idle(6);
    send(3'd1, 5'h10, 8'h3C);
    idle(5);

    // Illegal commands
    send(3'd6, 5'h00, 8'h11); idle(3);
    send(3'd7, 5'h03, 8'h22); idle(3);
    send(3'd0, 5'h08, 8'h33); idle(3);
    send(3'd1, 5'h0C, 8'h44); idle(3);
    send(3'd1, 5'h12, 8'h55); idle(3);

    // SAVE, LD_ACC 0xAA, RESTORE back-to-back with valid held
    send(3'd4, 5'h00, 8'h00);
    send(3'd2, 5'h00, 8'hAA);
    send(3'd5, 5'h00, 8'h00);
    idle(4);

    // valid pulses during LOAD/EXEC/SETTLE are ignored
    send(3'd0, 5'h03, 8'h11);
    cyc(1'b1, 3'd2, 5'h00, 8'h77);
    cyc(1'b1, 3'd6, 5'h1F, 8'h88);
    cyc(1'b1, 3'd1, 5'h10, 8'h99);
    idle(5);

    for (int k = 0; k < 3000; k++) begin
      logic [4:0] o;
      o = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      cyc(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), o, 8'($urandom));
    end

    @(negedge clk);
    compare_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
